// File: rtl/noc_output_port_switch.sv
// Output-port switch stage: forwards the granted input's flits through one register stage and
// tracks per-VC downstream credits. Define NOC_OUTPUT_PORT_CREDIT_CHECK_EN to add credit_err_o.
module noc_output_port_switch #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned FLIT_WIDTH   = 64,
  parameter int unsigned CREDIT_DEPTH = 4,
  parameter int unsigned VC_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    noc_clk,
  input  logic                    noc_rst_n,
  input  logic [4:0]              grant_i,
  output logic                    free_o,
  output logic [CHANNELS-1:0]     vc_ready_o,
  input  logic [4:0]              in_valid_i,
  input  logic [5*FLIT_WIDTH-1:0] in_data_i,
  input  logic [5*VC_W-1:0]       in_vc_i,
  input  logic [4:0]              in_tail_i,
  output logic [4:0]              in_ready_o,
  output logic                    out_valid_o,
  output logic [FLIT_WIDTH-1:0]   out_data_o,
  output logic [VC_W-1:0]         out_vc_o,
  output logic                    out_tail_o,
`ifdef NOC_OUTPUT_PORT_CREDIT_CHECK_EN
  output logic                    credit_err_o,
`endif
  input  logic [CHANNELS-1:0]     credit_i
);

  localparam int unsigned     CntW   = $clog2(CREDIT_DEPTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(CREDIT_DEPTH);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {StIdle, StFwd, StRelease} state_e;

  state_e                state_q, state_d;
  logic [4:0]            sel_q, sel_d;
  logic [CntW-1:0]       credit_q [CHANNELS];
  logic [CntW-1:0]       credit_d [CHANNELS];
  logic                  out_valid_q, out_valid_d;
  logic [FLIT_WIDTH-1:0] out_data_q, out_data_d;
  logic [VC_W-1:0]       out_vc_q, out_vc_d;
  logic                  out_tail_q, out_tail_d;
  logic                  free_q, free_d;

  logic                  grant_onehot;
  logic [4:0]            port_ok;
  logic                  accept;
  logic [FLIT_WIDTH-1:0] acc_data;
  logic [VC_W-1:0]       acc_vc;
  logic                  acc_tail;

  assign grant_onehot = (grant_i != 5'd0) && ((grant_i & (grant_i - 5'd1)) == 5'd0);

  // A port may send only if the VC its current flit targets has a credit left.
  always_comb begin
    port_ok = 5'd0;
    for (int p = 0; p < 5; p++) begin
      for (int v = 0; v < CHANNELS; v++) begin
        if ((in_vc_i[p*VC_W +: VC_W] == VC_W'(v)) && (credit_q[v] != '0)) begin
          port_ok[p] = 1'b1;
        end
      end
    end
  end

  assign in_ready_o = (state_q == StFwd) ? (sel_q & port_ok) : 5'd0;
  assign accept     = |(in_valid_i & in_ready_o);

  always_comb begin
    acc_data = '0;
    acc_vc   = '0;
    acc_tail = 1'b0;
    for (int p = 0; p < 5; p++) begin
      if (sel_q[p]) begin
        acc_data = in_data_i[p*FLIT_WIDTH +: FLIT_WIDTH];
        acc_vc   = in_vc_i[p*VC_W +: VC_W];
        acc_tail = in_tail_i[p];
      end
    end
  end

  // Simultaneous return and consume on one VC cancel; returns saturate at the buffer depth.
  always_comb begin
    for (int v = 0; v < CHANNELS; v++) begin
      credit_d[v] = credit_q[v];
      if (credit_i[v] && !(accept && (acc_vc == VC_W'(v)))) begin
        if (credit_q[v] != CntMax) credit_d[v] = credit_q[v] + CntOne;
      end else if (!credit_i[v] && accept && (acc_vc == VC_W'(v))) begin
        credit_d[v] = credit_q[v] - CntOne;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    free_d      = 1'b0;
    out_valid_d = accept;
    out_data_d  = out_data_q;
    out_vc_d    = out_vc_q;
    out_tail_d  = out_tail_q;
    if (accept) begin
      out_data_d = acc_data;
      out_vc_d   = acc_vc;
      out_tail_d = acc_tail;
    end
    case (state_q)
      StIdle: begin
        if (grant_onehot) begin
          sel_d   = grant_i;
          state_d = StFwd;
        end
      end
      StFwd: begin
        if (accept && acc_tail) begin
          state_d = StRelease;
          free_d  = 1'b1;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q     <= StIdle;
      sel_q       <= 5'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_vc_q    <= '0;
      out_tail_q  <= 1'b0;
      free_q      <= 1'b0;
      for (int v = 0; v < CHANNELS; v++) credit_q[v] <= CntMax;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_vc_q    <= out_vc_d;
      out_tail_q  <= out_tail_d;
      free_q      <= free_d;
      for (int v = 0; v < CHANNELS; v++) credit_q[v] <= credit_d[v];
    end
  end

  always_comb begin
    for (int v = 0; v < CHANNELS; v++) vc_ready_o[v] = (credit_q[v] != '0);
  end

  assign free_o      = free_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_vc_o    = out_vc_q;
  assign out_tail_o  = out_tail_q;

`ifdef NOC_OUTPUT_PORT_CREDIT_CHECK_EN
  logic err_q, err_d;
  logic grant_bad;
  logic overflow;

  assign grant_bad = (grant_i != 5'd0) && !grant_onehot;

  always_comb begin
    overflow = 1'b0;
    for (int v = 0; v < CHANNELS; v++) begin
      if (credit_i[v] && (credit_q[v] == CntMax)) overflow = 1'b1;
    end
    err_d = err_q | overflow | ((state_q == StIdle) && grant_bad);
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) err_q <= 1'b0;
    else            err_q <= err_d;
  end

  assign credit_err_o = err_q;
`endif

endmodule

// File: tb/tb_noc_output_port_switch.sv
// Bench for noc_output_port_switch: constant vector table, directed multi-cycle sequences and a
// random run, all checked against a transaction-level model of grants, packets and credits.
module tb_noc_output_port_switch;
  localparam int CH = 2;
  localparam int FW = 64;
  localparam int CD = 4;
  localparam int VW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    grant = '0, in_valid = '0, in_tail = '0, in_ready;
  logic [5*FW-1:0] in_data = '0;
  logic [5*VW-1:0] in_vc = '0;
  logic [CH-1:0] credit = '0, vc_ready;
  logic          free, out_valid, out_tail;
  logic [FW-1:0] out_data;
  logic [VW-1:0] out_vc;
`ifdef NOC_OUTPUT_PORT_CREDIT_CHECK_EN
  logic          credit_err;
`endif

  always #5 clk = ~clk;

  noc_output_port_switch #(
    .CHANNELS(CH), .FLIT_WIDTH(FW), .CREDIT_DEPTH(CD)
  ) dut (
    .noc_clk     (clk),
    .noc_rst_n   (rst_n),
    .grant_i     (grant),
    .free_o      (free),
    .vc_ready_o  (vc_ready),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_vc_i     (in_vc),
    .in_tail_i   (in_tail),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_vc_o    (out_vc),
    .out_tail_o  (out_tail),
`ifdef NOC_OUTPUT_PORT_CREDIT_CHECK_EN
    .credit_err_o(credit_err),
`endif
    .credit_i    (credit)
  );

  int nvec = 0, nerr = 0, d_ov = 0, d_free = 0;

  // Model: which port owns the link (-1 none), a one-cycle pop gap after each tail, credits.
  int            m_owner, m_hold, m_acc;
  int            m_credit [CH];
  logic          m_ov, m_otail, m_free, m_err;
  logic [FW-1:0] m_od;
  logic [VW-1:0] m_ovc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_hold = 0; m_acc = 0;
    for (int c = 0; c < CH; c++) m_credit[c] = CD;
    m_ov = 1'b0; m_otail = 1'b0; m_free = 1'b0; m_err = 1'b0; m_od = '0; m_ovc = '0;
  endtask

  function automatic logic [4:0] m_ready();
    logic [4:0] r = '0;
    if (m_owner >= 0 && m_credit[int'(in_vc[m_owner*VW +: VW])] > 0) r[m_owner] = 1'b1;
    return r;
  endfunction

  function automatic logic [CH-1:0] m_vcr();
    logic [CH-1:0] r = '0;
    for (int c = 0; c < CH; c++) r[c] = (m_credit[c] > 0);
    return r;
  endfunction

  task automatic model_step();
    logic [4:0] rdy;
    logic acc, tl;
    int v;
    rdy = m_ready();
    acc = 1'b0; tl = 1'b0; v = -1;
    if (m_owner >= 0) begin
      acc = in_valid[m_owner] && rdy[m_owner];
      tl  = in_tail[m_owner];
      v   = int'(in_vc[m_owner*VW +: VW]);
    end
    for (int c = 0; c < CH; c++) begin
      if (credit[c] && m_credit[c] == CD) m_err = 1'b1;
      if (credit[c] && !(acc && v == c)) m_credit[c] = (m_credit[c] < CD) ? m_credit[c] + 1 : CD;
      else if (!credit[c] && acc && v == c) m_credit[c]--;
    end
    m_ov   = acc;
    m_free = acc && tl;
    if (acc) begin
      m_od = in_data[m_owner*FW +: FW]; m_ovc = in_vc[m_owner*VW +: VW]; m_otail = tl; m_acc++;
    end
    if (acc && tl) begin
      m_owner = -1; m_hold = 1;
    end else if (m_owner < 0) begin
      if (m_hold > 0) m_hold = 0;
      else if ($countones(grant) == 1) begin
        for (int p = 0; p < 5; p++) if (grant[p]) m_owner = p;
      end else if (grant != 5'd0) m_err = 1'b1;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    chk("in_ready", 64'(in_ready), 64'(m_ready()));
    chk("vc_ready", 64'(vc_ready), 64'(m_vcr()));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("free", 64'(free), 64'(m_free));
    if (m_ov) begin
      chk("out_data", out_data, m_od);
      chk("out_vc", 64'(out_vc), 64'(m_ovc));
      chk("out_tail", 64'(out_tail), 64'(m_otail));
    end
`ifdef NOC_OUTPUT_PORT_CREDIT_CHECK_EN
    chk("credit_err", 64'(credit_err), 64'(m_err));
`endif
    if (out_valid) d_ov++;
    if (free) d_free++;
    model_step();
    @(negedge clk);
  endtask

  task automatic set_idle();
    grant = '0; in_valid = '0; in_tail = '0; in_vc = '0; credit = '0;
    for (int p = 0; p < 5; p++) in_data[p*FW +: FW] = {$urandom, $urandom};
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
    chk({tag, "_out_vc"}, 64'(out_vc), 64'd0);
    chk({tag, "_out_tail"}, 64'(out_tail), 64'd0);
    chk({tag, "_free"}, 64'(free), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_vc_ready"}, 64'(vc_ready), 64'h3);
`ifdef NOC_OUTPUT_PORT_CREDIT_CHECK_EN
    chk({tag, "_credit_err"}, 64'(credit_err), 64'd0);
`endif
  endtask

  typedef struct {
    logic [4:0] grant, valid, tail;
    logic [1:0] cred;
    logic [4:0] e_rdy;
    logic       e_ov, e_tail, e_free;
    logic [1:0] e_vcr;
  } vec_t;

  vec_t tbl [18];
  int   d0, f0, base;

  initial begin
    // 3-flit packet on port 2, credit return, back-to-back single-flit grants, bad grant.
    tbl[0]  = '{5'b00100, 5'b00000, 5'b00000, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[1]  = '{5'b00100, 5'b00100, 5'b00000, 2'b00, 5'b00100, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[2]  = '{5'b00100, 5'b00100, 5'b00000, 2'b00, 5'b00100, 1'b1, 1'b0, 1'b0, 2'b11};
    tbl[3]  = '{5'b00100, 5'b00100, 5'b00100, 2'b00, 5'b00100, 1'b1, 1'b0, 1'b0, 2'b11};
    tbl[4]  = '{5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 1'b1, 1'b1, 1'b1, 2'b11};
    tbl[5]  = '{5'b00000, 5'b00000, 5'b00000, 2'b01, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[6]  = '{5'b00000, 5'b00000, 5'b00000, 2'b01, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[7]  = '{5'b00000, 5'b00000, 5'b00000, 2'b01, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[8]  = '{5'b00001, 5'b00001, 5'b00001, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[9]  = '{5'b10000, 5'b10001, 5'b10001, 2'b00, 5'b00001, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[10] = '{5'b10000, 5'b10001, 5'b10001, 2'b00, 5'b00000, 1'b1, 1'b1, 1'b1, 2'b11};
    tbl[11] = '{5'b10000, 5'b10001, 5'b10001, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[12] = '{5'b10000, 5'b10001, 5'b10001, 2'b00, 5'b10000, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[13] = '{5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 1'b1, 1'b1, 1'b1, 2'b11};
    tbl[14] = '{5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[15] = '{5'b00011, 5'b00011, 5'b00000, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[16] = '{5'b00011, 5'b00011, 5'b00000, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[17] = '{5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0, 2'b11};

    set_idle();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 18; i++) begin
      set_idle();
      grant = tbl[i].grant; in_valid = tbl[i].valid; in_tail = tbl[i].tail; credit = tbl[i].cred;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_tail", i), 64'(out_tail), 64'(tbl[i].e_tail));
      chk($sformatf("tbl%0d_free", i), 64'(free), 64'(tbl[i].e_free));
      chk($sformatf("tbl%0d_vc_ready", i), 64'(vc_ready), 64'(tbl[i].e_vcr));
      cycle();
    end

    // 6-flit packet on VC1 with 4 credits: stalls after 4, resumes after two returns.
    d0 = d_ov; f0 = d_free; base = m_acc;
    for (int i = 0; i < 40; i++) begin
      set_idle();
      grant = 5'b00010; in_valid[1] = 1'b1; in_vc[1] = 1'b1; in_tail[1] = (m_acc - base == 5);
      if (i == 12 || i == 13) credit = 2'b10;
      cycle();
      if (i == 10) begin
        chk("stall_flits", 64'(d_ov - d0), 64'd4);
        chk("stall_in_ready", 64'(in_ready[1]), 64'd0);
        chk("stall_vc_ready", 64'(vc_ready[1]), 64'd0);
      end
      if (d_free != f0) break;
    end
    chk("vc1_pkt_flits", 64'(d_ov - d0), 64'd6);
    chk("vc1_pkt_free", 64'(d_free - f0), 64'd1);
    for (int i = 0; i < 4; i++) begin
      set_idle(); credit = 2'b10; cycle();
    end

    // VC0 sits at 2: a return coinciding with an accept leaves it at 2.
    d0 = d_ov;
    for (int i = 0; i < 6; i++) begin
      set_idle();
      if (i < 4) begin grant = 5'b01000; in_valid[3] = 1'b1; in_tail[3] = (i == 3); end
      if (i == 1) credit = 2'b01;
      cycle();
    end
    chk("same_cycle_flits", 64'(d_ov - d0), 64'd3);
    chk("same_cycle_vc0_empty", 64'(vc_ready[0]), 64'd0);
    // Five returns from empty: the fifth must saturate at 4.
    for (int i = 0; i < 5; i++) begin
      set_idle(); credit = 2'b01; cycle();
    end
    d0 = d_ov; f0 = d_free; base = m_acc;
    for (int i = 0; i < 30; i++) begin
      set_idle();
      grant = 5'b00100; in_valid[2] = 1'b1; in_tail[2] = (m_acc - base == 4);
      if (i == 12) credit = 2'b01;
      cycle();
      if (i == 9) begin
        chk("sat_flits", 64'(d_ov - d0), 64'd4);
        chk("sat_in_ready", 64'(in_ready[2]), 64'd0);
      end
      if (d_free != f0) break;
    end
    chk("sat_pkt_free", 64'(d_free - f0), 64'd1);
`ifdef NOC_OUTPUT_PORT_CREDIT_CHECK_EN
    chk("err_sticky", 64'(credit_err), 64'd1);
`endif

    // Reset during the second flit of a 4-flit packet.
    for (int i = 0; i < 2; i++) begin
      set_idle(); grant = 5'b00001; in_valid[0] = 1'b1; in_vc[0] = 1'b1; cycle();
    end
    chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
    set_idle(); grant = 5'b00001; in_valid[0] = 1'b1; in_vc[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_idle(); cycle();
    for (int i = 0; i < 3; i++) begin
      set_idle(); grant = 5'b00001; in_valid[0] = 1'b1; cycle();
    end

    for (int n = 0; n < 3000; n++) begin
      int r;
      set_idle();
      r = $urandom_range(0, 99);
      if (r < 70)      grant = 5'(1 << $urandom_range(0, 4));
      else if (r < 85) grant = 5'd0;
      else             grant = 5'($urandom);
      in_valid = 5'($urandom);
      in_vc    = 5'($urandom);
      for (int p = 0; p < 5; p++) in_tail[p] = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < CH; c++) credit[c] = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
